// File: rtl/burt_pkg.sv
// Shared types and constants for the Burt REDUCE vertical window generator.
package burt_pkg;
    localparam int FP16_EXP_WIDTH  = 5;
    localparam int FP16_FRAC_WIDTH = 10;
    localparam int FP_WIDTH        = 1 + FP16_EXP_WIDTH + FP16_FRAC_WIDTH;
    localparam int WINDOW_HEIGHT   = 5;
    // One line buffer per tap above the live pixel
    localparam int NUM_LB          = WINDOW_HEIGHT - 1;

    typedef enum logic [1:0] {FILL, STREAM, FLUSH} burt_vwin_state_t;
    typedef logic [FP_WIDTH-1:0] fp16_t;
endpackage

// File: rtl/burt_line_buffer.sv
// Single image line: combinational read and synchronous write at the same address.
// Contents are never reset; the window mux only selects lines already written.
module burt_line_buffer #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             i_we,
    input  logic [AW-1:0]    i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    output logic [WIDTH-1:0] o_rdata
);
    import burt_pkg::*;

    logic [WIDTH-1:0] r_mem [DEPTH];

    assign o_rdata = r_mem[i_addr];

    // Write the shifted-in value; read above sees the old line content
    always_ff @(posedge clk_i) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
    end
endmodule

// File: rtl/burt_v_window_fp16.sv
// Vertical 5x1 window generator for the fp16 Burt REDUCE vertical pass.
// Four line buffers shift a column upward on every accept; a clamp mux
// replicates the top rows at frame start and the bottom rows during FLUSH.
module burt_v_window_fp16 #(
    parameter int EXP_WIDTH     = 5,
    parameter int FRAC_WIDTH    = 10,
    parameter int IMAGE_WIDTH   = 640,
    parameter int IMAGE_HEIGHT  = 480,
    parameter int WINDOW_HEIGHT = 5
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic [EXP_WIDTH+FRAC_WIDTH:0]     pixel_i,
    input  logic                              valid_i,
    output logic                              ready_o,
    output logic [EXP_WIDTH+FRAC_WIDTH:0]     window_o [WINDOW_HEIGHT][1],
    output logic [15:0]                       col_o,
    output logic [15:0]                       row_o,
    output logic                              valid_o
);
    import burt_pkg::*;

    localparam int          FPW    = 1 + EXP_WIDTH + FRAC_WIDTH;
    localparam int          AW     = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1;
    localparam logic [15:0] LAST_C = 16'(IMAGE_WIDTH - 1);
    localparam logic [15:0] LAST_R = 16'(IMAGE_HEIGHT - 1);
    // Row counter keeps counting through FLUSH: H is pass 1, H+1 is pass 2
    localparam logic [15:0] PASS1_R = 16'(IMAGE_HEIGHT);
    localparam logic [15:0] PASS2_R = 16'(IMAGE_HEIGHT + 1);

    if (WINDOW_HEIGHT != burt_pkg::WINDOW_HEIGHT) begin : g_bad_taps
        $error("burt_v_window_fp16: WINDOW_HEIGHT must be 5");
    end
    if (IMAGE_WIDTH < 2 || IMAGE_HEIGHT < 5) begin : g_bad_dims
        $error("burt_v_window_fp16: need IMAGE_WIDTH>=2 and IMAGE_HEIGHT>=5");
    end

    burt_vwin_state_t              r_state, w_state_nxt;
    logic [15:0]                   r_c, r_r;
    logic                          w_acc, w_step, w_c_last, w_emit;
    logic [NUM_LB-1:0][FPW-1:0]    w_lb_rd, w_lb_wr;
    logic [FPW-1:0]                w_tap [5];
    logic [FPW-1:0]                r_win [5];
    logic [15:0]                   r_col, r_row;
    logic                          r_valid;

    assign ready_o  = (r_state != FLUSH);
    assign w_acc    = valid_i && ready_o;
    assign w_step   = w_acc || (r_state == FLUSH);
    assign w_c_last = (r_c == LAST_C);
    assign w_emit   = (w_acc && r_state == STREAM) || (r_state == FLUSH);

    // Line chain: pixel -> LB0 -> LB1 -> LB2 -> LB3, LBk holds row r-1-k
    for (genvar k = 0; k < NUM_LB; k++) begin : g_lb
        if (k == 0) begin : g_head
            assign w_lb_wr[k] = pixel_i;
        end else begin : g_link
            assign w_lb_wr[k] = w_lb_rd[k-1];
        end
        burt_line_buffer #(.DEPTH(IMAGE_WIDTH), .WIDTH(FPW), .AW(AW)) u_lb (
            .clk_i   (clk_i),
            .i_we    (w_acc),
            .i_addr  (r_c[AW-1:0]),
            .i_wdata (w_lb_wr[k]),
            .o_rdata (w_lb_rd[k])
        );
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= FILL;
        else        r_state <= w_state_nxt;
    end

    // Next state: frame phase changes on the last column of the boundary rows
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FILL:    if (w_acc && w_c_last && r_r == 16'd1)  w_state_nxt = STREAM;
            STREAM:  if (w_acc && w_c_last && r_r == LAST_R) w_state_nxt = FLUSH;
            FLUSH:   if (w_c_last && r_r == PASS2_R)         w_state_nxt = FILL;
            default: w_state_nxt = FILL;
        endcase
    end

    // Column/row counters advance on every accept or flush step
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_c <= '0;
            r_r <= '0;
        end else if (w_step) begin
            if (w_c_last) begin
                r_c <= '0;
                r_r <= (r_state == FLUSH && r_r == PASS2_R) ? 16'd0 : r_r + 16'd1;
            end else begin
                r_c <= r_c + 16'd1;
            end
        end
    end

    // Tap select with row-replicate clamping at top (rc=0,1) and bottom (FLUSH)
    always_comb begin
        w_tap[0] = w_lb_rd[3];
        w_tap[1] = w_lb_rd[2];
        w_tap[2] = w_lb_rd[1];
        w_tap[3] = w_lb_rd[0];
        w_tap[4] = (r_state == FLUSH) ? w_lb_rd[0] : pixel_i;
        if (r_state == FLUSH) begin
            if (r_r != PASS1_R) begin
                w_tap[0] = w_lb_rd[2];
                w_tap[1] = w_lb_rd[1];
                w_tap[2] = w_lb_rd[0];
            end
        end else if (r_r == 16'd2) begin
            w_tap[0] = w_lb_rd[1];
            w_tap[1] = w_lb_rd[1];
        end else if (r_r == 16'd3) begin
            w_tap[0] = w_lb_rd[2];
        end
    end

    // Output registers: one window per emitting step, centre row is r-2
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid <= 1'b0;
            r_col   <= '0;
            r_row   <= '0;
            for (int k = 0; k < 5; k++) r_win[k] <= '0;
        end else begin
            r_valid <= w_emit;
            if (w_emit) begin
                r_col <= r_c;
                r_row <= r_r - 16'd2;
                for (int k = 0; k < 5; k++) r_win[k] <= w_tap[k];
            end
        end
    end

    for (genvar k = 0; k < WINDOW_HEIGHT; k++) begin : g_out
        assign window_o[k][0] = r_win[k];
    end
    assign col_o   = r_col;
    assign row_o   = r_row;
    assign valid_o = r_valid;
endmodule

// File: tb/tb_burt_v_window_fp16.sv
// Self-checking bench for burt_v_window_fp16 at W=4, H=5.
// Reference: whole-frame image array, windows computed by clamped row lookup.
module tb_burt_v_window_fp16;
    localparam int W = 4;
    localparam int H = 5;
    typedef logic [111:0] ent_t;  // {row, col, tap0..tap4}

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        valid_i = 1'b0;
    logic [15:0] pixel_i = '0;
    logic        ready_o, valid_o;
    logic [15:0] window_o [5][1];
    logic [15:0] col_o, row_o;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   low_cnt = 0;
    int   spurious = 0;
    bit   prev_step = 1'b0;
    ent_t obs_q[$], exp_q[$];
    int   acc_cyc[$], out_cyc[$], low_runs[$];
    logic [15:0] img [H][W];
    logic [15:0] row_val [H] = '{16'h0000, 16'h3C00, 16'h4000, 16'h4200, 16'h4400};

    burt_v_window_fp16 #(
        .EXP_WIDTH(5), .FRAC_WIDTH(10), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .WINDOW_HEIGHT(5)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .pixel_i  (pixel_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .window_o (window_o),
        .col_o    (col_o),
        .row_o    (row_o),
        .valid_o  (valid_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc++;

    // Monitor: collect windows, accept times, ready-low run lengths, spurious outputs
    always @(negedge clk_i) begin
        if (valid_o) begin
            obs_q.push_back({row_o, col_o, window_o[0][0], window_o[1][0],
                             window_o[2][0], window_o[3][0], window_o[4][0]});
            out_cyc.push_back(cyc);
            if (!prev_step) spurious++;
        end
        prev_step = rst_i && ((valid_i && ready_o) || !ready_o);
        if (rst_i && valid_i && ready_o) acc_cyc.push_back(cyc);
        if (!ready_o) low_cnt++;
        else if (low_cnt > 0) begin
            low_runs.push_back(low_cnt);
            low_cnt = 0;
        end
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int clampr(input int r);
        return (r < 0) ? 0 : ((r > H - 1) ? H - 1 : r);
    endfunction

    // Golden frame: every (rc,c) in raster order, taps rc-2..rc+2 clamped
    task automatic build_exp();
        exp_q.delete();
        for (int rc = 0; rc < H; rc++)
            for (int c = 0; c < W; c++)
                exp_q.push_back({16'(rc), 16'(c), img[clampr(rc-2)][c], img[clampr(rc-1)][c],
                                 img[clampr(rc)][c], img[clampr(rc+1)][c], img[clampr(rc+2)][c]});
    endtask

    task automatic clear_mon();
        obs_q.delete(); acc_cyc.delete(); out_cyc.delete(); low_runs.delete();
        spurious = 0;
    endtask

    // Present one pixel (optionally after random idle cycles) and hold until accepted
    task automatic push_px(input logic [15:0] px, input int gap_pct);
        int n = 0;
        while ($urandom_range(99) < gap_pct) begin
            valid_i = 1'b0;
            @(posedge clk_i); #1;
        end
        valid_i = 1'b1;
        pixel_i = px;
        while (!ready_o && n < 100) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (n >= 100) begin
            checks++; failures++;
            $display("FAIL ready_timeout got=ready_low exp=ready_high");
        end
        @(posedge clk_i); #1;
    endtask

    // mode 0: row-coded fp16, 1: 0x3C00+16r+c, 2: random bit patterns
    task automatic drive_frame(input int mode, input int gap_pct);
        logic [15:0] px;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                px = (mode == 0) ? row_val[r] :
                     (mode == 1) ? 16'(16'h3C00 + 16 * r + c) : 16'($urandom);
                img[r][c] = px;
                push_px(px, gap_pct);
            end
    endtask

    task automatic drain();
        valid_i = 1'b0;
        repeat (2 * W + 10) @(posedge clk_i);
        #1;
    endtask

    task automatic cmp_frames(input string tag, input int nframes);
        chk({tag, "_count"}, obs_q.size(), nframes * W * H);
        for (int i = 0; i < obs_q.size() && i < nframes * W * H; i++)
            chk($sformatf("%s[%0d]", tag, i), obs_q[i], exp_q[i % (W * H)]);
        chk({tag, "_spurious"}, spurious, 0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, ready_o, 1'b1);
        chk({tag, "_valid"}, valid_o, 1'b0);
        chk({tag, "_outs"}, {row_o, col_o, window_o[0][0], window_o[1][0], window_o[2][0],
                             window_o[3][0], window_o[4][0]}, '0);
    endtask

    initial begin
        // Reset state
        #1;
        chk_reset_outs("reset");
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b1;
        clear_mon();

        // Two back-to-back frames; valid_i stays high across the first FLUSH
        drive_frame(0, 0);
        drive_frame(0, 0);
        drain();
        build_exp();
        chk("first_window", obs_q.size() > 0 ? obs_q[0] : '0,
            {16'd0, 16'd0, 16'h0000, 16'h0000, 16'h0000, 16'h3C00, 16'h4000});
        chk("first_latency", (out_cyc.size() > 0 && acc_cyc.size() > 8) ? out_cyc[0] - acc_cyc[8] : -1, 1);
        chk("flush_rc3", obs_q.size() > 12 ? obs_q[12] : '0,
            {16'd3, 16'd0, 16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4400});
        chk("flush_rc4", obs_q.size() > 16 ? obs_q[16] : '0,
            {16'd4, 16'd0, 16'h4000, 16'h4200, 16'h4400, 16'h4400, 16'h4400});
        chk("ready_low_runs", low_runs.size(), 2);
        for (int i = 0; i < low_runs.size(); i++)
            chk($sformatf("ready_low_len[%0d]", i), low_runs[i], 2 * W);
        chk("frame2_first_accept", acc_cyc.size(), 2 * W * H);
        cmp_frames("two_frames", 2);

        // Random 50% input gaps
        clear_mon();
        drive_frame(0, 50);
        drain();
        cmp_frames("gaps", 1);

        // Mid-frame reset after 7 accepts (FILL) and after 10 accepts (STREAM)
        for (int t = 0; t < 2; t++) begin
            int nacc = (t == 0) ? 7 : 10;
            clear_mon();
            for (int i = 0; i < nacc; i++) push_px(16'h7C01, 0);
            valid_i = 1'b0;
            #1 rst_i = 1'b0;
            #1 chk_reset_outs($sformatf("midreset%0d", nacc));
            @(posedge clk_i);
            #1 rst_i = 1'b1;
            clear_mon();
            drive_frame(0, 0);
            drain();
            build_exp();
            cmp_frames($sformatf("after_reset%0d", nacc), 1);
        end

        // Distinct per-pixel values
        clear_mon();
        drive_frame(1, 0);
        drain();
        build_exp();
        cmp_frames("distinct", 1);

        // Random bit patterns (NaN/inf included) with gaps
        clear_mon();
        drive_frame(2, 30);
        drain();
        build_exp();
        cmp_frames("random", 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule
